// File: rtl/fk_transform_chain.sv
// fk_transform_chain
// Builds the cumulative forward-kinematics transforms T_j = A_0 * A_1 * ... * A_j,
// one joint at a time, and hands each T_j to the Jacobian stage.
// Each element is computed in one cycle with four signed multipliers, so a
// joint takes 16 compute cycles.
//
// Ports:
//   clk_i        clock
//   reset_i      synchronous active-high reset
//   start_i      begin a new chain (only honoured while idle)
//   a_valid_i    A_j present on a_matrix_i
//   a_ready_o    block accepts A_j
//   a_matrix_i   A_j, element (r,c) at bits [(4r+c)*W +: W]
//   t_valid_o    T_j present on t_matrix_o
//   t_ready_i    downstream accepts T_j
//   t_matrix_o   T_j, same packing as a_matrix_i (zero when not valid)
//   t_joint_o    joint index j of t_matrix_o (zero when not valid)
//   busy_o       high in every state except idle
//   done_o       one-cycle pulse after the last T_j is accepted
//   overflow_o   sticky saturation flag, cleared by an accepted start
module fk_transform_chain #(
    parameter int unsigned N_JOINTS = 6,
    parameter int unsigned W        = 27,
    parameter int unsigned FRAC     = 22
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            start_i,
    input  logic            a_valid_i,
    output logic            a_ready_o,
    input  logic [16*W-1:0] a_matrix_i,
    output logic            t_valid_o,
    input  logic            t_ready_i,
    output logic [16*W-1:0] t_matrix_o,
    output logic [2:0]      t_joint_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            overflow_o
);

    localparam int unsigned PW = 2 * W;      // full product width
    localparam int unsigned SW = 2 * W + 2;  // 4-term sum width

    localparam logic signed [W-1:0]  One     = W'(1 << FRAC);
    localparam logic signed [W-1:0]  ElemMax = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]  ElemMin = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [SW-1:0] SumMax  = {{(W+3){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SumMin  = {{(W+3){1'b1}}, {(W-1){1'b0}}};
    localparam logic [2:0]           LastJoint = 3'(N_JOINTS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitA,
        StCompute,
        StOutput,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic signed [W-1:0] t_acc_q [16];
    logic signed [W-1:0] t_acc_d [16];
    logic signed [W-1:0] t_new_q [16];
    logic signed [W-1:0] t_new_d [16];
    logic signed [W-1:0] a_q     [16];
    logic signed [W-1:0] a_d     [16];
    logic [3:0]          idx_q, idx_d;
    logic [2:0]          joint_q, joint_d;
    logic                ovf_q, ovf_d;

    // Datapath: element (r,c) of T_acc * A for the current idx.
    logic signed [PW-1:0] prod [4];
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shifted;
    logic signed [W-1:0]  elem;
    logic                 clamp;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 4; k++) begin
            prod[k] = PW'(t_acc_q[{idx_q[3:2], k[1:0]}]) * PW'(a_q[{k[1:0], idx_q[1:0]}]);
            sum     = sum + SW'(prod[k]);
        end
        // Arithmetic shift gives floor division, no rounding.
        shifted = sum >>> FRAC;
        clamp   = 1'b0;
        if (shifted > SumMax) begin
            elem  = ElemMax;
            clamp = 1'b1;
        end else if (shifted < SumMin) begin
            elem  = ElemMin;
            clamp = 1'b1;
        end else begin
            elem = shifted[W-1:0];
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            for (int i = 0; i < 16; i++) begin
                t_acc_q[i] <= '0;
                t_new_q[i] <= '0;
                a_q[i]     <= '0;
            end
            idx_q   <= '0;
            joint_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_acc_q <= t_acc_d;
            t_new_q <= t_new_d;
            a_q     <= a_d;
            idx_q   <= idx_d;
            joint_q <= joint_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        t_acc_d = t_acc_q;
        t_new_d = t_new_q;
        a_d     = a_q;
        idx_d   = idx_q;
        joint_d = joint_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    for (int i = 0; i < 16; i++) begin
                        t_acc_d[i] = (i % 5 == 0) ? One : '0;
                    end
                    joint_d = '0;
                    ovf_d   = 1'b0;
                    state_d = StWaitA;
                end
            end
            StWaitA: begin
                if (a_valid_i) begin
                    for (int i = 0; i < 16; i++) begin
                        a_d[i] = a_matrix_i[i*W +: W];
                    end
                    idx_d   = '0;
                    state_d = StCompute;
                end
            end
            StCompute: begin
                t_new_d[idx_q] = elem;
                if (clamp) begin
                    ovf_d = 1'b1;
                end
                idx_d = idx_q + 4'd1;
                // T_acc stays untouched until all 16 products are done; the last
                // element bypasses t_new since it is only just being computed.
                if (idx_q == 4'd15) begin
                    for (int i = 0; i < 15; i++) begin
                        t_acc_d[i] = t_new_q[i];
                    end
                    t_acc_d[15] = elem;
                    state_d     = StOutput;
                end
            end
            StOutput: begin
                if (t_ready_i) begin
                    if (joint_q == LastJoint) begin
                        state_d = StDone;
                    end else begin
                        joint_d = joint_q + 3'd1;
                        state_d = StWaitA;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs
    always_comb begin
        a_ready_o  = (state_q == StWaitA);
        t_valid_o  = (state_q == StOutput);
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone);
        overflow_o = ovf_q;
        t_joint_o  = '0;
        t_matrix_o = '0;
        if (state_q == StOutput) begin
            t_joint_o = joint_q;
            for (int i = 0; i < 16; i++) begin
                t_matrix_o[i*W +: W] = t_acc_q[i];
            end
        end
    end

endmodule

// File: tb/tb_fk_transform_chain.sv
// tb_fk_transform_chain
// Self-checking bench for fk_transform_chain. Inputs are driven and outputs
// sampled on the falling clock edge. Expected transforms come from a plain
// integer matrix-product model with floor shift and saturation.
module tb_fk_transform_chain;

    localparam int W  = 27;
    localparam int MW = 16 * W;

    typedef logic signed [W-1:0] elem_t;
    typedef elem_t mat_t [16];

    localparam elem_t ONE  = 27'sh0400000;
    localparam elem_t HALF = 27'sh0200000;
    localparam elem_t FOUR = 27'sh1000000;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          a_valid;
    logic          a_ready;
    logic [MW-1:0] a_matrix;
    logic          t_valid;
    logic          t_ready;
    logic [MW-1:0] t_matrix;
    logic [2:0]    t_joint;
    logic          busy;
    logic          done;
    logic          overflow;

    int checks = 0;
    int passes = 0;

    // Reference model state
    mat_t tm;
    bit   model_ovf;

    always #5 clk = ~clk;

    fk_transform_chain #(
        .N_JOINTS (6),
        .W        (27),
        .FRAC     (22)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .start_i    (start),
        .a_valid_i  (a_valid),
        .a_ready_o  (a_ready),
        .a_matrix_i (a_matrix),
        .t_valid_o  (t_valid),
        .t_ready_i  (t_ready),
        .t_matrix_o (t_matrix),
        .t_joint_o  (t_joint),
        .busy_o     (busy),
        .done_o     (done),
        .overflow_o (overflow)
    );

    function automatic void set_ident(output mat_t m);
        for (int i = 0; i < 16; i++) m[i] = (i % 5 == 0) ? ONE : elem_t'(0);
    endfunction

    function automatic logic [MW-1:0] pack(input mat_t m);
        logic [MW-1:0] p;
        for (int i = 0; i < 16; i++) p[i*W +: W] = m[i];
        return p;
    endfunction

    function automatic elem_t rnd_elem();
        int v;
        v = int'($urandom_range(0, 8388608)) - 4194304;  // -1.0 .. +1.0
        return elem_t'(v);
    endfunction

    function automatic void rnd_mat(output mat_t m);
        for (int i = 0; i < 16; i++) m[i] = rnd_elem();
    endfunction

    // r = sat(floor((t * a) / 2^22)), ovf set when any element clamps
    function automatic void mm(input mat_t t, input mat_t a, output mat_t r, output bit ovf);
        longint s;
        ovf = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) begin
                s = 0;
                for (int k = 0; k < 4; k++) s += longint'(t[i*4+k]) * longint'(a[k*4+c]);
                s = s >>> 22;
                if (s > 67108863) begin
                    r[i*4+c] = elem_t'(67108863);
                    ovf = 1'b1;
                end else if (s < -67108864) begin
                    r[i*4+c] = elem_t'(-67108864);
                    ovf = 1'b1;
                end else begin
                    r[i*4+c] = elem_t'(s);
                end
            end
        end
    endfunction

    // Advance the model by one joint.
    task automatic model_step(input mat_t a);
        mat_t nt;
        bit   o;
        mm(tm, a, nt, o);
        tm        = nt;
        model_ovf = model_ovf | o;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        set_ident(tm);
        model_ovf = 1'b0;
    endtask

    // Offer A until accepted; optionally wait for t_valid. lat counts cycles
    // from the handshake cycle to the cycle where t_valid is seen.
    task automatic send_a(input logic [MW-1:0] m, input bit wait_out,
                          output int lat, output bit ok);
        int guard;
        guard    = 0;
        a_matrix = m;
        a_valid  = 1'b1;
        while (!a_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        ok = a_ready;
        @(negedge clk);
        a_valid = 1'b0;
        lat     = 1;
        if (wait_out) begin
            while (!t_valid && lat < 100) begin
                @(negedge clk);
                lat++;
            end
            ok = ok && t_valid;
        end
    endtask

    task automatic accept();
        t_ready = 1'b1;
        @(negedge clk);
        t_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({a_ready, t_valid, busy, done, overflow} !== 5'b0)
            $display("FAIL reset_ctrl: got %b want 00000", {a_ready, t_valid, busy, done, overflow});
        else passes++;
        checks++;
        if (t_matrix !== '0 || t_joint !== 3'd0)
            $display("FAIL reset_data: t_matrix=%h t_joint=%0d want 0/0", t_matrix, t_joint);
        else passes++;
    endtask

    task automatic test_identity();
        mat_t id;
        int   lat;
        bit   ok;
        set_ident(id);
        do_start();
        checks++;
        if (a_ready !== 1'b1 || busy !== 1'b1)
            $display("FAIL start_wait_a: a_ready=%b busy=%b want 1/1", a_ready, busy);
        else passes++;
        for (int j = 0; j < 6; j++) begin
            send_a(pack(id), 1'b1, lat, ok);
            checks++;
            if (!ok || t_joint !== 3'(j))
                $display("FAIL ident_joint: ok=%0d t_joint=%0d want %0d", ok, t_joint, j);
            else passes++;
            checks++;
            if (t_matrix !== pack(id))
                $display("FAIL ident_matrix j=%0d: got %h want %h", j, t_matrix, pack(id));
            else passes++;
            accept();
        end
        checks++;
        if (done !== 1'b1 || t_valid !== 1'b0)
            $display("FAIL ident_done: done=%b t_valid=%b want 1/0", done, t_valid);
        else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0)
            $display("FAIL ident_idle: done=%b busy=%b ovf=%b want 0/0/0", done, busy, overflow);
        else passes++;
    endtask

    task automatic test_translation();
        mat_t a, e;
        int   lat;
        bit   ok;
        set_ident(a);
        a[3] = HALF;
        do_start();
        for (int j = 0; j < 6; j++) begin
            send_a(pack(a), 1'b1, lat, ok);
            set_ident(e);
            e[3] = elem_t'((j + 1) * 2097152);
            checks++;
            if (!ok || t_matrix !== pack(e))
                $display("FAIL translate j=%0d: got %h want %h", j, t_matrix, pack(e));
            else passes++;
            accept();
        end
        checks++;
        if (t_matrix[3*W +: W] !== '0 || done !== 1'b1)
            $display("FAIL translate_done: done=%b want 1", done);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        mat_t r, id;
        int   lat;
        bit   ok;
        set_ident(id);
        for (int i = 0; i < 16; i++) r[i] = '0;
        r[1] = -ONE; r[4] = ONE; r[10] = ONE; r[15] = ONE;
        do_start();
        t_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            model_step(r);
            send_a(pack(r), 1'b1, lat, ok);
            checks++;
            if (!ok || lat !== 17)
                $display("FAIL rot_latency j=%0d: got %0d want 17", j, lat);
            else passes++;
            checks++;
            if (t_matrix !== pack(tm))
                $display("FAIL rot_matrix j=%0d: got %h want %h", j, t_matrix, pack(tm));
            else passes++;
            if (j == 0) begin
                checks++;
                if (t_matrix !== pack(r))
                    $display("FAIL rot_t0: got %h want %h", t_matrix, pack(r));
                else passes++;
            end
            if (j == 1) begin
                checks++;
                if (t_matrix[0 +: W] !== 27'h7C00000)
                    $display("FAIL rot_t1_00: got %h want 7c00000", t_matrix[0 +: W]);
                else passes++;
            end
            if (j == 3) begin
                checks++;
                if (t_matrix !== pack(id))
                    $display("FAIL rot_t3_ident: got %h want %h", t_matrix, pack(id));
                else passes++;
            end
            @(negedge clk);
            if (j < 5) begin
                checks++;
                if (a_ready !== 1'b1)
                    $display("FAIL rot_next_ready j=%0d: got %b want 1", j, a_ready);
                else passes++;
            end else begin
                checks++;
                if (done !== 1'b1 || t_valid !== 1'b0)
                    $display("FAIL rot_done: done=%b t_valid=%b want 1/0", done, t_valid);
                else passes++;
            end
        end
        t_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        mat_t a;
        int   lat;
        bit   ok;
        do_start();
        for (int j = 0; j < 6; j++) begin
            rnd_mat(a);
            model_step(a);
            send_a(pack(a), 1'b1, lat, ok);
            checks++;
            if (!ok || t_matrix !== pack(tm) || t_joint !== 3'(j))
                $display("FAIL bp_matrix j=%0d: got %h joint %0d want %h", j, t_matrix, t_joint,
                         pack(tm));
            else passes++;
            if (j == 2) begin
                for (int n = 0; n < 5; n++) begin
                    @(negedge clk);
                    checks++;
                    if (t_valid !== 1'b1 || a_ready !== 1'b0 || t_joint !== 3'd2
                        || t_matrix !== pack(tm))
                        $display("FAIL bp_hold n=%0d: valid=%b ready=%b joint=%0d got %h want %h",
                                 n, t_valid, a_ready, t_joint, t_matrix, pack(tm));
                    else passes++;
                end
            end
            accept();
        end
        checks++;
        if (done !== 1'b1 || overflow !== model_ovf)
            $display("FAIL bp_end: done=%b ovf=%b want 1/%b", done, overflow, model_ovf);
        else passes++;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        mat_t a;
        int   lat;
        bit   ok;
        for (int i = 0; i < 16; i++) a[i] = '0;
        a[0] = FOUR; a[5] = FOUR; a[10] = FOUR; a[15] = ONE;
        do_start();
        for (int j = 0; j < 6; j++) begin
            model_step(a);
            send_a(pack(a), 1'b1, lat, ok);
            checks++;
            if (!ok || t_matrix !== pack(tm))
                $display("FAIL sat_matrix j=%0d: got %h want %h", j, t_matrix, pack(tm));
            else passes++;
            if (j == 1) begin
                checks++;
                if (t_matrix[0 +: W] !== 27'h3FFFFFF || t_matrix[5*W +: W] !== 27'h3FFFFFF
                    || t_matrix[10*W +: W] !== 27'h3FFFFFF || t_matrix[15*W +: W] !== 27'h0400000)
                    $display("FAIL sat_t1_diag: got %h %h %h %h want 3ffffff x3, 0400000",
                             t_matrix[0 +: W], t_matrix[5*W +: W], t_matrix[10*W +: W],
                             t_matrix[15*W +: W]);
                else passes++;
                checks++;
                if (overflow !== 1'b1)
                    $display("FAIL sat_ovf_set: got %b want 1", overflow);
                else passes++;
            end
            accept();
        end
        @(negedge clk);
        checks++;
        if (overflow !== 1'b1 || busy !== 1'b0)
            $display("FAIL sat_ovf_sticky: ovf=%b busy=%b want 1/0", overflow, busy);
        else passes++;
        do_start();
        checks++;
        if (overflow !== 1'b0)
            $display("FAIL sat_ovf_clear: got %b want 0", overflow);
        else passes++;
    endtask

    task automatic test_control();
        mat_t a;
        int   lat;
        int   n;
        int   seen;
        bit   ok;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        do_start();
        for (int j = 0; j < 3; j++) begin
            rnd_mat(a);
            model_step(a);
            send_a(pack(a), 1'b0, lat, ok);
            if (j == 2) begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                checks++;
                if (busy !== 1'b1 || a_ready !== 1'b0 || t_valid !== 1'b0)
                    $display("FAIL ctl_start_ignored: busy=%b ready=%b valid=%b want 1/0/0",
                             busy, a_ready, t_valid);
                else passes++;
            end
            n = 0;
            while (!t_valid && n < 40) begin
                @(negedge clk);
                n++;
            end
            checks++;
            if (!ok || t_valid !== 1'b1 || t_joint !== 3'(j) || t_matrix !== pack(tm))
                $display("FAIL ctl_joint j=%0d: valid=%b joint=%0d got %h want %h", j, t_valid,
                         t_joint, t_matrix, pack(tm));
            else passes++;
            accept();
        end
        rnd_mat(a);
        send_a(pack(a), 1'b0, lat, ok);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if ({a_ready, t_valid, busy, done, overflow} !== 5'b0 || t_matrix !== '0
            || t_joint !== 3'd0)
            $display("FAIL ctl_reset_mid: ctrl=%b joint=%0d t_matrix=%h want all 0",
                     {a_ready, t_valid, busy, done, overflow}, t_joint, t_matrix);
        else passes++;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (t_valid || busy) seen++;
        end
        checks++;
        if (seen !== 0)
            $display("FAIL ctl_no_output: got %0d active cycles want 0", seen);
        else passes++;
    endtask

    task automatic test_random();
        mat_t a;
        int   lat;
        bit   ok;
        for (int ch = 0; ch < 3; ch++) begin
            do_start();
            for (int j = 0; j < 6; j++) begin
                rnd_mat(a);
                model_step(a);
                send_a(pack(a), 1'b1, lat, ok);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                checks++;
                if (!ok || t_valid !== 1'b1 || t_joint !== 3'(j) || t_matrix !== pack(tm))
                    $display("FAIL rand c=%0d j=%0d: joint=%0d got %h want %h", ch, j, t_joint,
                             t_matrix, pack(tm));
                else passes++;
                accept();
            end
            checks++;
            if (done !== 1'b1 || overflow !== model_ovf)
                $display("FAIL rand_end c=%0d: done=%b ovf=%b want 1/%b", ch, done, overflow,
                         model_ovf);
            else passes++;
            @(negedge clk);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        a_valid  = 1'b0;
        a_matrix = '0;
        t_ready  = 1'b0;
        model_ovf = 1'b0;
        set_ident(tm);
        repeat (3) @(negedge clk);
        test_reset();
        test_identity();
        test_translation();
        test_rotation();
        test_backpressure();
        test_saturation();
        test_control();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passes, checks);
        $fatal(1);
    end

endmodule

// File: doc/fk_transform_chain.md
Name: fk_transform_chain

Overview:
- Upstream stage of the Jacobian block: builds the cumulative forward-kinematics transforms T_j = A_0·A_1·…·A_j, one joint at a time.
- Host/DH stage supplies one 4x4 homogeneous link matrix A_j per joint over a ready/valid handshake.
- After each joint, the block presents T_j and the joint index to the Jacobian stage, with backpressure.
- Uses 4 signed multipliers and produces one output element per cycle.

Parameters:
N_JOINTS, 6, joints per chain (1..7; index fits 3 bits)
W, 27, element width, signed two's complement
FRAC, 22, fractional bits (Q5.22; 1.0 = 0x0400000)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  begin new chain; honoured only in IDLE
a_valid  in  1  A_j present on a_matrix
a_ready  out  1  block accepts A_j
a_matrix  in  16*W  A_j; element (r,c) at bits [(4r+c)*W +: W]
t_valid  out  1  T_j present on t_matrix
t_ready  in  1  Jacobian stage accepts T_j
t_matrix  out  16*W  T_j, same packing as a_matrix
t_joint  out  3  joint index j of t_matrix
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last T is accepted
overflow  out  1  sticky saturation flag; cleared on accepted start

Behaviour:
- Reset: state=IDLE; a_ready, t_valid, busy, done, overflow = 0; t_matrix = 0; t_joint = 0; internal T_acc = 0. Reset mid-operation aborts the chain; no partial output is emitted.
- IDLE: on start, T_acc <= identity, j <= 0, overflow <= 0; go to WAIT_A. start in any other state is ignored.
- WAIT_A: a_ready=1. On a_valid&a_ready, latch A and set idx <= 0; go to COMPUTE. a_ready drops the next cycle.
- COMPUTE: 16 cycles; idx = 0..15, with r = idx[3:2] and c = idx[1:0].
  - Each cycle: T_new[r][c] <= sat((Σ_k T_acc[r][k]·A[k][c]) >>> FRAC).
  - T_acc is not modified during COMPUTE.
  - When idx = 15: T_acc <= T_new including element 15, then go to OUTPUT.
- OUTPUT: t_valid=1, t_matrix=T_acc, t_joint=j. Both stay stable while t_ready=0.
  - On t_ready, if j = N_JOINTS-1: go to DONE.
  - On t_ready otherwise: j <= j+1 and go to WAIT_A.
- DONE: done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- Latency: a handshake in cycle 0 puts COMPUTE in cycles 1..16; t_valid rises in cycle 17. With t_ready held high, the next a_ready is cycle 18.
- Arithmetic:
  - Products are full 2W-bit signed; the 4-term sum uses 2W+2 bits.
  - Arithmetic shift right by FRAC (floor, no rounding).
  - Saturate to [0x4000000, 0x3FFFFFF] (-16.0 .. 16.0-2^-22). Any clamp sets overflow.
- Bottom row is computed generically, not forced to [0 0 0 1].
- Simultaneous t_valid&t_ready in the last joint: done is asserted the following cycle, never together with t_valid.

Test Plan:
1. Identity chain: start, then six A=identity, t_ready=1 → six t_valid pulses with t_joint 0..5, each t_matrix=identity (diagonal 0x0400000, others 0); done 1 cycle after the 6th; overflow=0.
2. Translation chain: every A=identity with (0,3)=0x0200000 (0.5) → T_j(0,3) = (j+1)·0x0200000, so 0x0C00000 at j=5; all other elements identity.
3. Rotation: A = Rz(90°) = [[0,-1,0,0],[1,0,0,0],[0,0,1,0],[0,0,0,1]] each joint → T_0 = Rz90, T_1(0,0) = 0x7C00000 (-1.0), T_3 = identity exactly; latency from A handshake to t_valid = 17 cycles.
4. Backpressure: hold t_ready=0 for 5 cycles at joint 2 → t_valid, t_matrix and t_joint stable, a_ready=0 throughout; the next joint proceeds after release.
5. Saturation: A = diag(4.0,4.0,4.0,1.0) (0x1000000) each joint → T_1 diagonal 0x3FFFFFF on rows 0..2, overflow=1 and stays set; next accepted start clears it.
6. Control: start pulsed during COMPUTE is ignored; reset asserted mid-COMPUTE at joint 3 → next cycle: IDLE, all outputs 0, no t_valid; a fresh chain then runs correctly.
